// File: rtl/mioc_pkg.sv
// Shared encodings for the ADAM memory/IO controller: map field codes, DRAM states, I/O port decodes.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mioc_pkg;

    // Lower map field (0x0000-0x7FFF)
    localparam logic [1:0] LMAP_BOOT = 2'b00;
    localparam logic [1:0] LMAP_RAM  = 2'b01;
    localparam logic [1:0] LMAP_XRAM = 2'b10;
    localparam logic [1:0] LMAP_OS7  = 2'b11;

    // Upper map field (0x8000-0xFFFF)
    localparam logic [1:0] UMAP_RAM  = 2'b00;
    localparam logic [1:0] UMAP_XROM = 2'b01;
    localparam logic [1:0] UMAP_XRAM = 2'b10;
    localparam logic [1:0] UMAP_CART = 2'b11;

    // I/O port decodes on {BA7, BA6}
    localparam logic [1:0] MAP_WR_PORT  = 2'b01;
    localparam logic [1:0] IS3_PORT     = 2'b00;
    localparam logic [1:0] SPIN_OFF_PORT = 2'b10;
    localparam logic [1:0] SPIN_ON_PORT  = 2'b11;

    typedef enum logic [1:0] {
        DRAM_IDLE = 2'b00,
        DRAM_ROW  = 2'b01,
        DRAM_COL  = 2'b10,
        DRAM_PRE  = 2'b11
    } dram_state_e;

endpackage

// File: rtl/mioc_dram_ctl.sv
// DRAM strobe sequencer: IDLE -> ROW -> COL -> PRE for RAM accesses, ROW-only for refresh.
// Latency: RAS one edge after request, MUX/CAS one edge later; strobes decoded from state.
// Backpressure: wait_n low holds the current state; rst forces IDLE.
// Ports: clk, rst (any reset source), bmreq_n/rfsh_n/wait_n strobes, ram_sel from the
//        map decode, ba15/ba7 address bits; outputs ras_n, cas1_n, cas2_n, mux, ra7.
module mioc_dram_ctl
    import mioc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic bmreq_n,
    input  logic rfsh_n,
    input  logic wait_n,
    input  logic ram_sel,
    input  logic ba15,
    input  logic ba7,
    output logic ras_n,
    output logic cas1_n,
    output logic cas2_n,
    output logic mux,
    output logic ra7
);

    dram_state_e state_q, state_d;
    // Remembers that the cycle in ROW is a refresh, so it never advances to COL.
    logic        rfsh_q, rfsh_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DRAM_IDLE;
            rfsh_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rfsh_q  <= rfsh_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rfsh_d  = rfsh_q;
        ras_n   = 1'b1;
        cas1_n  = 1'b1;
        cas2_n  = 1'b1;
        mux     = 1'b0;
        case (state_q)
            DRAM_IDLE: begin
                if (!bmreq_n && (ram_sel || !rfsh_n)) begin
                    state_d = DRAM_ROW;
                    rfsh_d  = !rfsh_n;
                end
            end
            DRAM_ROW: begin
                ras_n = 1'b0;
                if (bmreq_n)      state_d = DRAM_PRE;
                else if (!rfsh_q) state_d = DRAM_COL;
            end
            DRAM_COL: begin
                ras_n  = 1'b0;
                mux    = 1'b1;
                cas1_n = ba15;
                cas2_n = !ba15;
                if (bmreq_n) state_d = DRAM_PRE;
            end
            DRAM_PRE: begin
                state_d = DRAM_IDLE;
            end
            default: state_d = DRAM_IDLE;
        endcase
        if (!wait_n) begin
            state_d = state_q;
            rfsh_d  = rfsh_q;
        end
    end

    assign ra7 = mux ? ba15 : ba7;

endmodule

// File: rtl/mioc_asic.sv
// ADAM memory/IO controller: map register, ROM/expansion decode, DRAM sequencing, resets, 6801 handshake.
// Latency: selects combinational; RAS +1 edge, CAS +2 edges; BUSRQ_N +1 edge; resets stretched RST_STRETCH edges.
// Backpressure: WAIT_N low freezes the DRAM sequencer; no other stalls.
// Ports: B_PHI clock, RESET sync active-high; BA*/BD* address/data bits; Z80 strobes (active low);
//        DRAM strobes RAS_N/CAS1_N/CAS2_N/MUX/RA7; decode selects; bus control; reset outputs;
//        SPINDIS_N; IS3_N/OS3_N handshake with the master 6801.
module mioc_asic
    import mioc_pkg::*;
#(
    parameter int RST_STRETCH = 16
) (
    input  logic B_PHI,
    input  logic RESET,
    input  logic BA15, BA14, BA13, BA7, BA6,
    input  logic BD3, BD2, BD1, BD0,
    input  logic N_BWR, BRD_N, BMREQ_N, BRFSH_N, BM1_N, IORQ_N,
    input  logic WAIT_N, BUSAK_N, DMA_N, OS3_N, PBRST_N, N_CVRST,
    output logic RA7,
    output logic RAS_N, CAS1_N, CAS2_N, MUX,
    output logic BOOTROMCS_N, AUXROMCS_N, AUXDECODE1_N, EN245_N,
    output logic ADDRBUFEN_N, BUSRQ_N,
    output logic RST_N, NETRST_N, CPRST_N,
    output logic SPINDIS_N,
    output logic IS3_N
);

    localparam int CW = $clog2(RST_STRETCH + 1);

    // Opcode fetches decode exactly like ordinary reads.
    logic unused_m1;
    assign unused_m1 = BM1_N;

    logic src_pb, src_cv, src_any, src_net, src_cp;
    assign src_pb  = !PBRST_N;
    assign src_cv  = !N_CVRST;
    assign src_any = RESET || src_pb || src_cv;
    assign src_net = RESET || src_pb;
    assign src_cp  = RESET || src_cv;

    // Reset stretchers: reload while a source is active, count down after release.
    function automatic logic [CW-1:0] stretch_next(input logic src, input logic [CW-1:0] cnt);
        if (src)            return CW'(RST_STRETCH);
        else if (cnt != '0) return cnt - CW'(1);
        else                return cnt;
    endfunction

    logic [CW-1:0] rst_cnt_q, rst_cnt_d, net_cnt_q, net_cnt_d, cp_cnt_q, cp_cnt_d;
    logic          rst_n_q, rst_n_d, netrst_n_q, netrst_n_d, cprst_n_q, cprst_n_d;

    always_comb begin
        rst_cnt_d  = stretch_next(src_any, rst_cnt_q);
        net_cnt_d  = stretch_next(src_net, net_cnt_q);
        cp_cnt_d   = stretch_next(src_cp,  cp_cnt_q);
        rst_n_d    = (rst_cnt_d == '0);
        netrst_n_d = (net_cnt_d == '0);
        cprst_n_d  = (cp_cnt_d  == '0);
    end

    // I/O side: map register, spinner disable, IS3 strobe, bus request.
    logic [1:0] io_port;
    logic       io_wr;
    logic [3:0] map_q, map_d;
    logic       spindis_n_q, spindis_n_d, is3_n_q, is3_n_d, busrq_n_q, busrq_n_d;

    assign io_port = {BA7, BA6};
    assign io_wr   = !IORQ_N && !N_BWR;

    always_comb begin
        map_d = map_q;
        if (io_wr && io_port == MAP_WR_PORT) map_d = {BD3, BD2, BD1, BD0};
        spindis_n_d = spindis_n_q;
        if (io_wr && io_port == SPIN_OFF_PORT) spindis_n_d = 1'b0;
        if (io_wr && io_port == SPIN_ON_PORT)  spindis_n_d = 1'b1;
        is3_n_d = is3_n_q;
        if (!IORQ_N && io_port == IS3_PORT) is3_n_d = 1'b0;
        if (!OS3_N)                          is3_n_d = 1'b1;  // acknowledge wins
        busrq_n_d = DMA_N;
    end

    always_ff @(posedge B_PHI) begin
        rst_cnt_q  <= rst_cnt_d;
        net_cnt_q  <= net_cnt_d;
        cp_cnt_q   <= cp_cnt_d;
        rst_n_q    <= rst_n_d;
        netrst_n_q <= netrst_n_d;
        cprst_n_q  <= cprst_n_d;
        if (src_any) begin
            // Cartridge reset boots OS7 + cartridge; it outranks the push-button reset.
            map_q       <= (src_cv && !RESET) ? 4'b1111 : 4'b0000;
            spindis_n_q <= 1'b1;
            is3_n_q     <= 1'b1;
            busrq_n_q   <= 1'b1;
        end else begin
            map_q       <= map_d;
            spindis_n_q <= spindis_n_d;
            is3_n_q     <= is3_n_d;
            busrq_n_q   <= busrq_n_d;
        end
    end

    // Memory decode (combinational).
    logic mem_rd, mem_acc;
    logic boot_sel, xrom_sel, xdec_sel, en245_sel, ram_sel;

    assign mem_rd  = !BMREQ_N && BRFSH_N && !BRD_N;
    assign mem_acc = !BMREQ_N && BRFSH_N && (!BRD_N || !N_BWR);

    always_comb begin
        boot_sel  = 1'b0;
        xrom_sel  = 1'b0;
        xdec_sel  = 1'b0;
        en245_sel = 1'b0;
        ram_sel   = 1'b0;
        if (mem_acc && !src_any) begin
            if (!BA15) begin
                case (map_q[1:0])
                    LMAP_BOOT: boot_sel = mem_rd;
                    LMAP_RAM:  ram_sel  = 1'b1;
                    LMAP_XRAM: xdec_sel = 1'b1;
                    LMAP_OS7: begin
                        // OS7 ROM occupies only the first 8K; RAM fills the rest.
                        if (!BA14 && !BA13) en245_sel = mem_rd;
                        else                ram_sel   = 1'b1;
                    end
                    default: ;
                endcase
            end else begin
                case (map_q[3:2])
                    UMAP_RAM:  ram_sel   = 1'b1;
                    UMAP_XROM: xrom_sel  = mem_rd;
                    UMAP_XRAM: xdec_sel  = 1'b1;
                    UMAP_CART: en245_sel = mem_rd;
                    default: ;
                endcase
            end
        end
    end

    mioc_dram_ctl u_dram (
        .clk     (B_PHI),
        .rst     (src_any),
        .bmreq_n (BMREQ_N),
        .rfsh_n  (BRFSH_N),
        .wait_n  (WAIT_N),
        .ram_sel (ram_sel),
        .ba15    (BA15),
        .ba7     (BA7),
        .ras_n   (RAS_N),
        .cas1_n  (CAS1_N),
        .cas2_n  (CAS2_N),
        .mux     (MUX),
        .ra7     (RA7)
    );

    assign BOOTROMCS_N  = !boot_sel;
    assign AUXROMCS_N   = !xrom_sel;
    assign AUXDECODE1_N = !xdec_sel;
    assign EN245_N      = !en245_sel;
    assign ADDRBUFEN_N  = !BUSAK_N;
    assign BUSRQ_N      = busrq_n_q;
    assign RST_N        = rst_n_q;
    assign NETRST_N     = netrst_n_q;
    assign CPRST_N      = cprst_n_q;
    assign SPINDIS_N    = spindis_n_q;
    assign IS3_N        = is3_n_q;

endmodule

// File: tb/tb_mioc_asic.sv
// Bench for mioc_asic: directed scenarios plus randomized map/address decode against a range-based model.
// Latency: checks sample 1 time unit after each rising edge; inputs change at the same point.
// Backpressure: WAIT_N exercised in the DRAM scenario only.
module tb_mioc_asic;

    logic B_PHI = 1'b0;
    logic RESET;
    logic BA15, BA14, BA13, BA7, BA6, BD3, BD2, BD1, BD0;
    logic N_BWR, BRD_N, BMREQ_N, BRFSH_N, BM1_N, IORQ_N;
    logic WAIT_N, BUSAK_N, DMA_N, OS3_N, PBRST_N, N_CVRST;
    logic RA7, RAS_N, CAS1_N, CAS2_N, MUX;
    logic BOOTROMCS_N, AUXROMCS_N, AUXDECODE1_N, EN245_N;
    logic ADDRBUFEN_N, BUSRQ_N, RST_N, NETRST_N, CPRST_N, SPINDIS_N, IS3_N;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] model_map;

    always #5 B_PHI = ~B_PHI;

    mioc_asic #(.RST_STRETCH(16)) dut (
        .B_PHI(B_PHI), .RESET(RESET),
        .BA15(BA15), .BA14(BA14), .BA13(BA13), .BA7(BA7), .BA6(BA6),
        .BD3(BD3), .BD2(BD2), .BD1(BD1), .BD0(BD0),
        .N_BWR(N_BWR), .BRD_N(BRD_N), .BMREQ_N(BMREQ_N), .BRFSH_N(BRFSH_N),
        .BM1_N(BM1_N), .IORQ_N(IORQ_N),
        .WAIT_N(WAIT_N), .BUSAK_N(BUSAK_N), .DMA_N(DMA_N), .OS3_N(OS3_N),
        .PBRST_N(PBRST_N), .N_CVRST(N_CVRST),
        .RA7(RA7), .RAS_N(RAS_N), .CAS1_N(CAS1_N), .CAS2_N(CAS2_N), .MUX(MUX),
        .BOOTROMCS_N(BOOTROMCS_N), .AUXROMCS_N(AUXROMCS_N),
        .AUXDECODE1_N(AUXDECODE1_N), .EN245_N(EN245_N),
        .ADDRBUFEN_N(ADDRBUFEN_N), .BUSRQ_N(BUSRQ_N),
        .RST_N(RST_N), .NETRST_N(NETRST_N), .CPRST_N(CPRST_N),
        .SPINDIS_N(SPINDIS_N), .IS3_N(IS3_N)
    );

    task automatic tick();
        @(posedge B_PHI);
        #1;
    endtask

    task automatic bus_idle();
        BA15 = 0; BA14 = 0; BA13 = 0; BA7 = 0; BA6 = 0;
        {BD3, BD2, BD1, BD0} = 4'b0000;
        N_BWR = 1; BRD_N = 1; BMREQ_N = 1; BRFSH_N = 1; BM1_N = 1; IORQ_N = 1;
    endtask

    task automatic io_write(input logic a7, input logic a6, input logic [3:0] d);
        BA7 = a7; BA6 = a6; {BD3, BD2, BD1, BD0} = d;
        IORQ_N = 0; N_BWR = 0;
        tick();
        IORQ_N = 1; N_BWR = 1;
    endtask

    task automatic set_addr(input logic [15:0] a);
        BA15 = a[15]; BA14 = a[14]; BA13 = a[13]; BA7 = a[7]; BA6 = a[6];
    endtask

    // Reference memory map: returns {boot, auxrom, auxdec, en245, ram}, active high.
    function automatic logic [4:0] model_sel(input logic [3:0] map, input logic [15:0] addr,
                                             input logic rd, input logic wr);
        logic [1:0] lo, hi;
        lo = map[1:0];
        hi = map[3:2];
        if (!rd && !wr) return 5'b00000;
        if (addr < 16'h8000) begin
            if (lo == 2'd0) return {rd, 4'b0000};
            if (lo == 2'd1) return 5'b00001;
            if (lo == 2'd2) return 5'b00100;
            if (addr < 16'h2000) return {3'b000, rd, 1'b0};
            return 5'b00001;
        end
        if (hi == 2'd0) return 5'b00001;
        if (hi == 2'd1) return {1'b0, rd, 3'b000};
        if (hi == 2'd2) return 5'b00100;
        return {3'b000, rd, 1'b0};
    endfunction

    task automatic test_reset();
        int len;
        len = $urandom_range(1, 5);
        RESET = 1;
        set_addr(16'h0000); BMREQ_N = 0; BRD_N = 0;
        repeat (len) tick();
        n_checks++;
        if ({RST_N, NETRST_N, CPRST_N} !== 3'b000) begin
            n_fail++; $display("FAIL reset_outs: got %b, expected 000", {RST_N, NETRST_N, CPRST_N});
        end
        n_checks++;
        if ({BOOTROMCS_N, AUXROMCS_N, AUXDECODE1_N, EN245_N} !== 4'b1111) begin
            n_fail++; $display("FAIL reset_selects: got %b, expected 1111",
                               {BOOTROMCS_N, AUXROMCS_N, AUXDECODE1_N, EN245_N});
        end
        n_checks++;
        if ({RAS_N, CAS1_N, CAS2_N, MUX, BUSRQ_N, IS3_N, SPINDIS_N} !== 7'b1110111) begin
            n_fail++; $display("FAIL reset_regs: got %b, expected 1110111",
                               {RAS_N, CAS1_N, CAS2_N, MUX, BUSRQ_N, IS3_N, SPINDIS_N});
        end
        RESET = 0; bus_idle();
        model_map = 4'b0000;
        // Outputs rise once 16 edges have passed with no source asserted.
        for (int k = 1; k <= 20; k++) begin
            logic e;
            tick();
            e = (k >= 16);
            n_checks++;
            if ({RST_N, NETRST_N, CPRST_N} !== {e, e, e}) begin
                n_fail++; $display("FAIL reset_stretch k=%0d: got %b, expected %b",
                                   k, {RST_N, NETRST_N, CPRST_N}, {e, e, e});
            end
        end
    endtask

    task automatic test_boot();
        set_addr(16'h2000); BMREQ_N = 0; BRD_N = 0;
        #1;
        n_checks++;
        if (BOOTROMCS_N !== 1'b0) begin
            n_fail++; $display("FAIL boot_cs: got %b, expected 0", BOOTROMCS_N);
        end
        tick();
        n_checks++;
        if ({RAS_N, BUSRQ_N} !== 2'b11) begin
            n_fail++; $display("FAIL boot_no_ras: got %b, expected 11", {RAS_N, BUSRQ_N});
        end
        BMREQ_N = 1; BRD_N = 1;
        #1;
        n_checks++;
        if (BOOTROMCS_N !== 1'b1) begin
            n_fail++; $display("FAIL boot_cs_release: got %b, expected 1", BOOTROMCS_N);
        end
        tick();
    endtask

    task automatic test_dram();
        io_write(0, 1, 4'b0001);
        model_map = 4'b0001;
        set_addr(16'h0080); BMREQ_N = 0; BRD_N = 0;
        #1;
        n_checks++;
        if ({RA7, RAS_N} !== 2'b11) begin
            n_fail++; $display("FAIL dram_pre_edge: got %b, expected 11", {RA7, RAS_N});
        end
        tick();
        n_checks++;
        if ({RAS_N, MUX, CAS1_N, CAS2_N} !== 4'b0011) begin
            n_fail++; $display("FAIL dram_row: got %b, expected 0011", {RAS_N, MUX, CAS1_N, CAS2_N});
        end
        tick();
        n_checks++;
        if ({RAS_N, MUX, CAS1_N, CAS2_N, RA7} !== 5'b01010) begin
            n_fail++; $display("FAIL dram_col: got %b, expected 01010", {RAS_N, MUX, CAS1_N, CAS2_N, RA7});
        end
        WAIT_N = 0; BMREQ_N = 1; BRD_N = 1;
        tick();
        n_checks++;
        if ({RAS_N, MUX, CAS1_N} !== 3'b010) begin
            n_fail++; $display("FAIL dram_wait_hold: got %b, expected 010", {RAS_N, MUX, CAS1_N});
        end
        WAIT_N = 1;
        tick();
        n_checks++;
        if ({RAS_N, MUX, CAS1_N, CAS2_N} !== 4'b1011) begin
            n_fail++; $display("FAIL dram_pre: got %b, expected 1011", {RAS_N, MUX, CAS1_N, CAS2_N});
        end
        // New request arrives during PRE: one idle edge must pass before RAS.
        BMREQ_N = 0; BRD_N = 0;
        tick();
        n_checks++;
        if (RAS_N !== 1'b1) begin
            n_fail++; $display("FAIL dram_pre_to_idle: got %b, expected 1", RAS_N);
        end
        tick();
        n_checks++;
        if (RAS_N !== 1'b0) begin
            n_fail++; $display("FAIL dram_idle_to_row: got %b, expected 0", RAS_N);
        end
        bus_idle();
        tick(); tick();
    endtask

    task automatic test_refresh();
        BRFSH_N = 0; BMREQ_N = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if ({RAS_N, CAS1_N, CAS2_N, MUX} !== 4'b0110) begin
                n_fail++; $display("FAIL refresh k=%0d: got %b, expected 0110", k, {RAS_N, CAS1_N, CAS2_N, MUX});
            end
        end
        BRFSH_N = 1; BMREQ_N = 1;
        tick();
        n_checks++;
        if (RAS_N !== 1'b1) begin
            n_fail++; $display("FAIL refresh_end: got %b, expected 1", RAS_N);
        end
        tick();
    endtask

    task automatic test_dma();
        DMA_N = 0;
        #1;
        n_checks++;
        if (BUSRQ_N !== 1'b1) begin
            n_fail++; $display("FAIL busrq_early: got %b, expected 1", BUSRQ_N);
        end
        tick();
        n_checks++;
        if (BUSRQ_N !== 1'b0) begin
            n_fail++; $display("FAIL busrq_assert: got %b, expected 0", BUSRQ_N);
        end
        DMA_N = 1;
        tick();
        n_checks++;
        if (BUSRQ_N !== 1'b1) begin
            n_fail++; $display("FAIL busrq_release: got %b, expected 1", BUSRQ_N);
        end
        for (int k = 0; k < 2; k++) begin
            BUSAK_N = logic'(k);
            #1;
            n_checks++;
            if (ADDRBUFEN_N !== !BUSAK_N) begin
                n_fail++; $display("FAIL addrbufen busak=%b: got %b, expected %b", BUSAK_N, ADDRBUFEN_N, !BUSAK_N);
            end
        end
        BUSAK_N = 1;
        tick();
    endtask

    task automatic test_is3();
        BA7 = 0; BA6 = 0; IORQ_N = 0; BRD_N = 0;
        tick();
        IORQ_N = 1; BRD_N = 1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (IS3_N !== 1'b0) begin
                n_fail++; $display("FAIL is3_held k=%0d: got %b, expected 0", k, IS3_N);
            end
            tick();
        end
        OS3_N = 0;
        tick();
        OS3_N = 1;
        n_checks++;
        if (IS3_N !== 1'b1) begin
            n_fail++; $display("FAIL is3_ack: got %b, expected 1", IS3_N);
        end
        // Set and acknowledge on the same edge: acknowledge wins.
        IORQ_N = 0; BRD_N = 0; OS3_N = 0;
        tick();
        IORQ_N = 1; BRD_N = 1; OS3_N = 1;
        n_checks++;
        if (IS3_N !== 1'b1) begin
            n_fail++; $display("FAIL is3_clear_wins: got %b, expected 1", IS3_N);
        end
    endtask

    task automatic test_spindis();
        io_write(1, 0, 4'b0000);
        n_checks++;
        if (SPINDIS_N !== 1'b0) begin
            n_fail++; $display("FAIL spindis_set: got %b, expected 0", SPINDIS_N);
        end
        BA7 = 1; BA6 = 1; IORQ_N = 0; BRD_N = 0;  // read: no effect
        tick();
        IORQ_N = 1; BRD_N = 1;
        n_checks++;
        if (SPINDIS_N !== 1'b0) begin
            n_fail++; $display("FAIL spindis_read_ignored: got %b, expected 0", SPINDIS_N);
        end
        io_write(1, 1, 4'b0000);
        n_checks++;
        if (SPINDIS_N !== 1'b1) begin
            n_fail++; $display("FAIL spindis_clear: got %b, expected 1", SPINDIS_N);
        end
    endtask

    task automatic test_pbrst();
        int gap;
        io_write(0, 1, 4'b0001);
        PBRST_N = 0;
        repeat (3) tick();
        PBRST_N = 1;
        gap = $urandom_range(2, 10);
        for (int k = 1; k <= gap; k++) begin
            tick();
            n_checks++;
            if ({RST_N, NETRST_N, CPRST_N} !== 3'b001) begin
                n_fail++; $display("FAIL pbrst_first k=%0d: got %b, expected 001", k, {RST_N, NETRST_N, CPRST_N});
            end
        end
        PBRST_N = 0;  // re-assert mid-stretch: count restarts
        tick();
        PBRST_N = 1;
        model_map = 4'b0000;
        for (int k = 1; k <= 18; k++) begin
            logic e;
            tick();
            e = (k >= 16);
            n_checks++;
            if ({RST_N, NETRST_N, CPRST_N} !== {e, e, 1'b1}) begin
                n_fail++; $display("FAIL pbrst_stretch k=%0d: got %b, expected %b",
                                   k, {RST_N, NETRST_N, CPRST_N}, {e, e, 1'b1});
            end
        end
        set_addr(16'h0000); BMREQ_N = 0; BRD_N = 0;
        #1;
        n_checks++;
        if (BOOTROMCS_N !== 1'b0) begin
            n_fail++; $display("FAIL pbrst_map_cleared: got %b, expected 0", BOOTROMCS_N);
        end
        bus_idle();
        tick();
    endtask

    task automatic test_cvrst();
        N_CVRST = 0;
        repeat (2) tick();
        n_checks++;
        if ({RST_N, NETRST_N, CPRST_N} !== 3'b010) begin
            n_fail++; $display("FAIL cvrst_outs: got %b, expected 010", {RST_N, NETRST_N, CPRST_N});
        end
        N_CVRST = 1;
        model_map = 4'b1111;
        for (int k = 1; k <= 17; k++) begin
            logic e;
            tick();
            e = (k >= 16);
            n_checks++;
            if ({RST_N, NETRST_N, CPRST_N} !== {e, 1'b1, e}) begin
                n_fail++; $display("FAIL cvrst_stretch k=%0d: got %b, expected %b",
                                   k, {RST_N, NETRST_N, CPRST_N}, {e, 1'b1, e});
            end
        end
        for (int i = 0; i < 3; i++) begin
            logic [15:0] a;
            logic        exp_en;
            a = (i == 0) ? 16'h0000 : (i == 1) ? 16'h8000 : 16'h4000;
            exp_en = (i == 2);
            set_addr(a); BMREQ_N = 0; BRD_N = 0;
            #1;
            n_checks++;
            if (EN245_N !== exp_en) begin
                n_fail++; $display("FAIL cvrst_en245 addr=%h: got %b, expected %b", a, EN245_N, exp_en);
            end
            tick();
            n_checks++;
            if (RAS_N !== !exp_en) begin
                n_fail++; $display("FAIL cvrst_ras addr=%h: got %b, expected %b", a, RAS_N, !exp_en);
            end
            bus_idle();
            tick(); tick();
        end
    endtask

    task automatic test_decode_random();
        for (int it = 0; it < 24; it++) begin
            logic [15:0] a;
            logic [3:0]  m;
            logic [4:0]  e;
            int          kind;
            logic        rd, wr;
            m = 4'($urandom_range(0, 15));
            io_write(0, 1, m);
            model_map = m;
            a = 16'($urandom_range(0, 65535));
            kind = $urandom_range(0, 2);
            rd = (kind == 0);
            wr = (kind == 1);
            set_addr(a); BMREQ_N = 0; BRD_N = !rd; N_BWR = !wr;
            e = model_sel(model_map, a, rd, wr);
            #1;
            n_checks++;
            if ({BOOTROMCS_N, AUXROMCS_N, AUXDECODE1_N, EN245_N, RA7} !== {~e[4:1], a[7]}) begin
                n_fail++; $display("FAIL decode map=%b addr=%h kind=%0d: got %b, expected %b", m, a, kind,
                                   {BOOTROMCS_N, AUXROMCS_N, AUXDECODE1_N, EN245_N, RA7}, {~e[4:1], a[7]});
            end
            tick();
            n_checks++;
            if (RAS_N !== !e[0]) begin
                n_fail++; $display("FAIL decode_ras map=%b addr=%h: got %b, expected %b", m, a, RAS_N, !e[0]);
            end
            tick();
            n_checks++;
            if ({RAS_N, MUX, CAS1_N, CAS2_N, RA7} !==
                (e[0] ? {2'b01, a[15], !a[15], a[15]} : {4'b1011, a[7]})) begin
                n_fail++; $display("FAIL decode_cas map=%b addr=%h: got %b, expected %b", m, a,
                                   {RAS_N, MUX, CAS1_N, CAS2_N, RA7},
                                   (e[0] ? {2'b01, a[15], !a[15], a[15]} : {4'b1011, a[7]}));
            end
            bus_idle();
            tick();
            n_checks++;
            if ({RAS_N, MUX} !== 2'b10) begin
                n_fail++; $display("FAIL decode_release addr=%h: got %b, expected 10", a, {RAS_N, MUX});
            end
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        bus_idle();
        RESET = 1; WAIT_N = 1; BUSAK_N = 1; DMA_N = 1; OS3_N = 1; PBRST_N = 1; N_CVRST = 1;
        model_map = 4'b0000;
        test_reset();
        test_boot();
        test_dram();
        test_refresh();
        test_dma();
        test_is3();
        test_spindis();
        test_pbrst();
        test_cvrst();
        test_decode_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mioc_asic.md
Name: mioc_asic

Overview:
- Memory/IO controller for the ADAM-style Z80 system; clocked by the Z80 clock B_PHI.
- Holds the 4-bit memory-map register and decodes Z80 or 6801-DMA accesses into ROM/expansion chip selects.
- Sequences DRAM RAS/MUX/CAS and RA7.
- Generates the system, AdamNET and cartridge resets, the DMA bus request, the spinner disable, and the IS3/OS3 handshake with the master 6801.

Parameters:
- RST_STRETCH, 16, B_PHI cycles RST_N/NETRST_N/CPRST_N stay low after all reset sources release.

Ports:
- B_PHI in 1: clock; all state changes on rising edge.
- RESET in 1: synchronous, active-high power-on reset.
- BA15, BA14, BA13, BA7, BA6 in 1 each: buffered address bits.
- BD3..BD0 in 1 each: data bits, map register write data.
- N_BWR, BRD_N, BMREQ_N, BRFSH_N, BM1_N, IORQ_N in 1: buffered Z80 strobes, active low.
- WAIT_N, BUSAK_N, DMA_N, OS3_N, PBRST_N, N_CVRST in 1: active-low inputs.
- RA7 out 1: multiplexed DRAM address MSB.
- RAS_N, CAS1_N, CAS2_N, MUX out 1: DRAM control.
- BOOTROMCS_N, AUXROMCS_N, AUXDECODE1_N, EN245_N out 1: decode selects.
- ADDRBUFEN_N, BUSRQ_N out 1: bus control.
- RST_N, NETRST_N, CPRST_N out 1: resets.
- SPINDIS_N out 1: spinner interrupt disable.
- IS3_N out 1: strobe to 6801.

Behaviour:
- Reset sources are RESET, PBRST_N low, and N_CVRST low; PBRST_N and N_CVRST are sampled synchronously.
- On any source, all registers load their reset values:
  - RST_N=0.
  - NETRST_N=0 (RESET or PBRST_N only; otherwise 1).
  - CPRST_N=0 (RESET or N_CVRST only; otherwise 1).
  - Chip selects, RAS_N, CAS1_N, CAS2_N, BUSRQ_N, IS3_N, SPINDIS_N = 1; MUX=0.
- Reset release:
  - Each reset output goes high RST_STRETCH cycles after its last source deasserts.
  - A source reasserting mid-stretch restarts the count.
- Map register MAP[3:0] {upper[1:0]=BD3:BD2, lower[1:0]=BD1:BD0}:
  - Reset value 0000 for RESET/PBRST_N.
  - N_CVRST loads 1111 (OS7 + cartridge); it has priority when asserted together with PBRST_N.
  - Written on a rising edge with IORQ_N=0, N_BWR=0, BA7=0, BA6=1.
- Memory cycle qualifier: BMREQ_N=0 and BRFSH_N=1. Reads need BRD_N=0; writes need N_BWR=0.
- Address 0x0000-0x7FFF (BA15=0), by lower field:
  - 00: BOOTROMCS_N=0 (reads only).
  - 01: internal RAM.
  - 10: AUXDECODE1_N=0.
  - 11: 0x0000-0x1FFF (BA14=BA13=0) gives EN245_N=0 on reads; the rest is internal RAM.
- Address 0x8000-0xFFFF (BA15=1), by upper field:
  - 00: internal RAM.
  - 01: AUXROMCS_N=0 (reads).
  - 10: AUXDECODE1_N=0.
  - 11: EN245_N=0 (reads).
- Decode selects are combinational from the qualifier and MAP.
- Writes to ROM regions select nothing.
- BM1_N has no effect; an opcode fetch is an ordinary read.
- DRAM FSM states IDLE, ROW, COL, PRE:
  - IDLE→ROW when BMREQ_N=0 and (internal RAM selected or BRFSH_N=0). In ROW: RAS_N=0, MUX=0.
  - ROW→COL next edge, but only for a RAM access. In COL: MUX=1 and RAS_N=0; CAS1_N=0 if BA15=0, else CAS2_N=0.
  - Refresh stays in ROW (CAS_N high) until BMREQ_N=1.
  - WAIT_N=0 freezes the FSM.
  - ROW/COL→PRE when BMREQ_N=1. PRE drives all strobes inactive and MUX=0, then returns to IDLE.
  - Reset mid-cycle forces IDLE.
- RA7 = MUX ? BA15 : BA7 (combinational).
- ADDRBUFEN_N = ~BUSAK_N (combinational).
- BUSRQ_N = DMA_N registered, one-cycle latency.
- SPINDIS_N:
  - I/O write (IORQ_N=0, N_BWR=0) with BA7=1, BA6=0 sets it to 0.
  - An I/O write with BA7=1, BA6=1 sets it to 1.
- IS3_N:
  - Set to 0 on an I/O access (IORQ_N=0) with BA7=0, BA6=0.
  - Returns to 1 the cycle after OS3_N is sampled 0.
  - If the set and clear conditions occur together, the clear wins.

Decomposition:
- Package mioc_pkg holds:
  - Map field encodings: LMAP_BOOT=00, LMAP_RAM=01, LMAP_XRAM=10, LMAP_OS7=11; UMAP_RAM=00, UMAP_XROM=01, UMAP_XRAM=10, UMAP_CART=11.
  - DRAM state enum.
  - The port-decode constant for the map write (BA7=0, BA6=1).
- One sub-module, mioc_dram_ctl: the FSM plus RAS/CAS/MUX/RA7.

Test Plan:
- RESET or PBRST_N low 3 cycles, then release → RST_N and NETRST_N low through release + 16 cycles, then 1; CPRST_N stays 1 after RESET ends; MAP=0000.
- After reset, BMREQ_N=0, BRD_N=0, BA15=0, BA13=1 → BOOTROMCS_N=0 same cycle, RAS_N stays 1, BUSRQ_N=1; BMREQ_N=1 → BOOTROMCS_N=1.
- I/O write BA7=0, BA6=1, BD=0001, then read BA15=0 → RAS_N=0 edge 1, MUX=1 and CAS1_N=0 edge 2, RA7 switches BA7→BA15; BMREQ_N high → PRE, then IDLE.
- BRFSH_N=0, BMREQ_N=0 → RAS_N=0, CAS1_N=CAS2_N=1, MUX=0 for the whole refresh.
- N_CVRST low → CPRST_N low; MAP=1111; read 0x0000 → EN245_N=0; read 0x8000 → EN245_N=0.
- DMA_N=0 → BUSRQ_N=0 one cycle later; BUSAK_N=0 → ADDRBUFEN_N=1.
- I/O access BA7=0, BA6=0 → IS3_N=0, held until OS3_N=0, then 1.
- I/O write BA7=1, BA6=0 → SPINDIS_N=0; write BA7=1, BA6=1 → SPINDIS_N=1.
